// File: rtl/parking_exit_controller_if.sv
// Exit-gate bundle: car/ticket/coin sensors in, gate, LEDs and
// occupancy status out.
interface parking_exit_controller_if;
  logic       sensor_exit;
  logic [1:0] ticket;
  logic       coin;
  logic       sensor_clear;
  logic       car_entered;
  logic       GREEN_LED;
  logic       RED_LED;
  logic       gate_open;
  logic       car_exited;
  logic [2:0] occupancy;
  logic [2:0] credit;
  logic       full;
  logic       empty;

  modport master (
    output sensor_exit, ticket, coin, sensor_clear, car_entered,
    input  GREEN_LED, RED_LED, gate_open, car_exited,
    input  occupancy, credit, full, empty
  );

  modport slave (
    input  sensor_exit, ticket, coin, sensor_clear, car_entered,
    output GREEN_LED, RED_LED, gate_open, car_exited,
    output occupancy, credit, full, empty
  );
endinterface

// File: rtl/parking_exit_controller.sv
// Parking exit gate: ticket check, coin payment, timed gate
// opening and occupancy tracking shared with the entry side.
module parking_exit_controller #(
  parameter int CAPACITY         = 6,
  parameter int FEE              = 3,
  parameter int GATE_OPEN_CYCLES = 8,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input logic clk,
  input logic reset_n,
  parking_exit_controller_if.slave bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GO_LAST = 8'(GATE_OPEN_CYCLES - 1);
  localparam logic [3:0] FEE_W   = 4'(FEE);
  localparam logic [2:0] CAP_W   = 3'(CAPACITY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRONG,
    S_PAY,
    S_OPEN
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [2:0] r_credit;
  logic [2:0] w_credit_nxt;
  logic [2:0] r_occ;
  logic       r_exited;
  logic       w_leave;
  logic       w_ok;

  assign w_ok    = (bus.ticket == 2'b11);
  assign w_leave = (r_state == S_OPEN) && bus.sensor_clear;

  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = 8'd0;
    w_credit_nxt = r_credit;
    unique case (r_state)
      S_IDLE: begin
        if (bus.sensor_exit && (r_occ != 3'd0))
          w_next = S_CHECK;
      end
      S_CHECK: begin
        w_next = w_ok ? S_PAY : S_WRONG;
      end
      S_WRONG: begin
        if (w_ok)
          w_next = S_PAY;
        else if (r_cnt == TO_LAST)
          w_next = S_IDLE;
        else
          w_cnt_nxt = r_cnt + 8'd1;
      end
      S_PAY: begin
        // a coin restarts the idle timeout, so the counter stays 0
        if (bus.coin) begin
          if (({1'b0, r_credit} + 4'd1) >= FEE_W) begin
            w_next       = S_OPEN;
            w_credit_nxt = 3'd0;
          end else begin
            w_credit_nxt = r_credit + 3'd1;
          end
        end else if (r_cnt == TO_LAST) begin
          w_next       = S_IDLE;
          w_credit_nxt = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_OPEN: begin
        if (bus.sensor_clear || (r_cnt == GO_LAST))
          w_next = S_IDLE;
        else
          w_cnt_nxt = r_cnt + 8'd1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_credit <= 3'd0;
      r_exited <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_nxt;
      r_credit <= w_credit_nxt;
      r_exited <= w_leave;
    end
  end

  // simultaneous entry and exit cancel out
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_occ <= 3'd0;
    end else if (bus.car_entered && !w_leave) begin
      if (r_occ != CAP_W)
        r_occ <= r_occ + 3'd1;
    end else if (!bus.car_entered && w_leave) begin
      if (r_occ != 3'd0)
        r_occ <= r_occ - 3'd1;
    end
  end

  assign bus.GREEN_LED  = (r_state == S_OPEN);
  assign bus.gate_open  = (r_state == S_OPEN);
  assign bus.RED_LED    = (r_state == S_WRONG);
  assign bus.car_exited = r_exited;
  assign bus.occupancy  = r_occ;
  assign bus.credit     = r_credit;
  assign bus.full       = (r_occ == CAP_W);
  assign bus.empty      = (r_occ == 3'd0);

endmodule

// File: tb/tb_parking_exit_controller.sv
// Bench for parking_exit_controller: directed scenarios followed
// by random traffic, all checked against a behavioural model.
module tb_parking_exit_controller;

  localparam int CAP = 6;
  localparam int FEE = 3;
  localparam int GOC = 8;
  localparam int TOC = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  parking_exit_controller_if bus();

  parking_exit_controller #(
    .CAPACITY(CAP),
    .FEE(FEE),
    .GATE_OPEN_CYCLES(GOC),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: 0 idle, 1 check, 2 wrong ticket, 3 pay, 4 open
  int ph = 0;
  int spent = 0;
  int cr = 0;
  int occ = 0;
  bit ex = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit se, input bit [1:0] tk,
                       input bit cn, input bit sc, input bit ce,
                       input bit rn);
    int  nph;
    bit  restart;
    bit  gone;
    if (!rn) begin
      ph = 0; spent = 0; cr = 0; occ = 0; ex = 1'b0;
      return;
    end
    nph = ph;
    restart = 1'b0;
    gone = (ph == 4) && sc;
    case (ph)
      0: if (se && occ > 0) nph = 1;
      1: nph = (tk == 2'b11) ? 3 : 2;
      2: begin
        if (tk == 2'b11) nph = 3;
        else if (spent + 1 >= TOC) nph = 0;
      end
      3: begin
        if (cn) begin
          restart = 1'b1;
          cr = cr + 1;
          if (cr >= FEE) begin cr = 0; nph = 4; end
        end else if (spent + 1 >= TOC) begin
          cr = 0; nph = 0;
        end
      end
      4: if (sc || spent + 1 >= GOC) nph = 0;
      default: nph = 0;
    endcase
    spent = (nph != ph || restart || nph < 2) ? 0 : spent + 1;
    ph = nph;
    ex = gone;
    occ = occ + int'(ce) - int'(gone);
    if (occ > CAP) occ = CAP;
    if (occ < 0) occ = 0;
  endtask

  task automatic step(input bit se, input bit [1:0] tk,
                      input bit cn, input bit sc, input bit ce,
                      input bit rn);
    bus.sensor_exit  = se;
    bus.ticket       = tk;
    bus.coin         = cn;
    bus.sensor_clear = sc;
    bus.car_entered  = ce;
    reset_n          = rn;
    @(posedge clk);
    model(se, tk, cn, sc, ce, rn);
    #1;
    chk("gate_open", 8'(bus.gate_open), 8'(ph == 4));
    chk("green", 8'(bus.GREEN_LED), 8'(ph == 4));
    chk("red", 8'(bus.RED_LED), 8'(ph == 2));
    chk("car_exited", 8'(bus.car_exited), 8'(ex));
    chk("occupancy", 8'(bus.occupancy), 8'(occ));
    chk("credit", 8'(bus.credit), 8'(cr));
    chk("full", 8'(bus.full), 8'(occ == CAP));
    chk("empty", 8'(bus.empty), 8'(occ == 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 0, 1);
  endtask

  initial begin
    bus.sensor_exit  = 1'b0;
    bus.ticket       = 2'b00;
    bus.coin         = 1'b0;
    bus.sensor_clear = 1'b0;
    bus.car_entered  = 1'b0;

    // reset state
    step(0, 2'b00, 0, 0, 0, 0);
    step(1, 2'b11, 1, 1, 1, 0);
    chk("rst_empty", 8'(bus.empty), 8'd1);
    chk("rst_occ", 8'(bus.occupancy), 8'd0);

    // empty lot: exit request and coins ignored
    for (int i = 0; i < 5; i++) step(1, 2'b11, 1, 0, 0, 1);
    chk("empty_credit", 8'(bus.credit), 8'd0);
    chk("empty_gate", 8'(bus.gate_open), 8'd0);

    // three cars in, paid exit
    for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 0, 1, 1);
    step(1, 2'b11, 0, 0, 0, 1);
    step(0, 2'b11, 0, 0, 0, 1);
    step(0, 2'b00, 1, 0, 0, 1);
    step(0, 2'b00, 0, 0, 0, 1);
    step(0, 2'b00, 1, 0, 0, 1);
    chk("pay_credit2", 8'(bus.credit), 8'd2);
    step(0, 2'b00, 1, 0, 0, 1);
    chk("open_gate", 8'(bus.gate_open), 8'd1);
    chk("open_credit", 8'(bus.credit), 8'd0);
    step(0, 2'b00, 0, 0, 0, 1);
    step(0, 2'b00, 0, 1, 0, 1);
    chk("exit_pulse", 8'(bus.car_exited), 8'd1);
    chk("exit_occ", 8'(bus.occupancy), 8'd2);
    idle(1);
    chk("exit_pulse_end", 8'(bus.car_exited), 8'd0);

    // wrong ticket, corrected, then payment timeout
    step(1, 2'b11, 0, 0, 0, 1);
    step(1, 2'b01, 0, 0, 0, 1);
    chk("wrong_red", 8'(bus.RED_LED), 8'd1);
    step(0, 2'b01, 1, 0, 0, 1);
    step(0, 2'b11, 0, 0, 0, 1);
    chk("fix_red", 8'(bus.RED_LED), 8'd0);
    idle(15);
    step(0, 2'b00, 1, 0, 0, 1);
    idle(16);
    chk("pay_to_credit", 8'(bus.credit), 8'd0);
    step(0, 2'b00, 1, 0, 0, 1);
    chk("idle_coin_ign", 8'(bus.credit), 8'd0);

    // wrong ticket timing out
    step(1, 2'b00, 0, 0, 0, 1);
    step(0, 2'b10, 0, 0, 0, 1);
    idle(15);
    chk("wrong_hold", 8'(bus.RED_LED), 8'd1);
    idle(1);
    chk("wrong_to", 8'(bus.RED_LED), 8'd0);

    // gate timeout without clearance
    step(1, 2'b11, 0, 0, 0, 1);
    step(0, 2'b11, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 1, 0, 0, 1);
    idle(7);
    chk("gate_hold", 8'(bus.gate_open), 8'd1);
    idle(1);
    chk("gate_to", 8'(bus.gate_open), 8'd0);
    chk("gate_to_occ", 8'(bus.occupancy), 8'd2);
    idle(2);

    // saturation and simultaneous entry/exit
    for (int i = 0; i < 7; i++) step(0, 2'b00, 0, 0, 1, 1);
    chk("sat_full", 8'(bus.full), 8'd1);
    chk("sat_occ", 8'(bus.occupancy), 8'd6);
    step(1, 2'b11, 0, 0, 0, 1);
    step(0, 2'b11, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 1, 0, 0, 1);
    step(0, 2'b00, 0, 1, 1, 1);
    chk("swap_occ", 8'(bus.occupancy), 8'd6);
    chk("swap_pulse", 8'(bus.car_exited), 8'd1);

    // reset mid-payment
    step(1, 2'b11, 0, 0, 0, 1);
    step(0, 2'b11, 0, 0, 0, 1);
    step(0, 2'b00, 1, 0, 0, 1);
    step(0, 2'b00, 1, 0, 0, 1);
    step(0, 2'b00, 1, 1, 1, 0);
    chk("mid_rst_credit", 8'(bus.credit), 8'd0);
    chk("mid_rst_empty", 8'(bus.empty), 8'd1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit [1:0] tk;
      tk = ($urandom_range(0, 3) != 0) ? 2'b11
                                       : 2'($urandom_range(0, 3));
      step(bit'($urandom_range(0, 1)), tk,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 199) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
